cordic_atan_sched: RTL and testbench
====================================

CORDIC_ATAN_SCHED -- requirements
Module: cordic_atan_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter ITERATIONS, default 7, meaning CORDIC iterations per job (1..7).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester job request.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot grant/accept strobe.
REQ-007 SHALL have port req_x  input  NREQ*16  signed x operands, requester k at bits [16k+15:16k].
REQ-008 SHALL have port req_y  input  NREQ*16  signed y operands, same packing.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  output  3  index of requester owning the result.
REQ-012 SHALL have port rsp_atan  output  16  signed angle, Q3.12 radians.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 SHALL, in IDLE with any req_valid high, assert req_ready for exactly one granted requester in that same cycle (combinational from req_valid and priority state), latch its x/y, z=0, i=0, go RUN.
REQ-016 SHALL never assert req_ready outside IDLE; req_ready SHALL be all-zero when no req_valid is high.
REQ-017 SHALL perform one iteration per RUN cycle: if y>0 then x'=x+(y>>>i), y'=y-(x>>>i), z'=z+T[i], else x'=x-(y>>>i), y'=y+(x>>>i), z'=z-T[i], using pre-update x and y (simultaneous update).
REQ-018 SHALL hold x and y in 18-bit signed registers (sign-extended inputs) so gain growth (~1.65) cannot overflow; z SHALL be 16-bit signed.
REQ-019 SHALL use table T = {3217, 1899, 1003, 509, 256, 128, 64} (atan(2^-i) in Q3.12), entries beyond ITERATIONS unused.
REQ-020 SHALL leave RUN after ITERATIONS cycles to DONE, asserting rsp_valid with rsp_atan=z, rsp_id=granted index; accept-to-rsp_valid latency = ITERATIONS+1 cycles.
REQ-021 SHALL hold rsp_valid, rsp_atan, rsp_id stable in DONE until rsp_ready high, then return to IDLE next cycle; no new grant in the handshake cycle.
REQ-022 SHALL apply no quadrant correction; inputs with x<0 produce the raw iteration result, not a fault.
REQ-023 SHALL treat req_x/req_y as sampled only in the accept cycle; later changes have no effect on the job.

Reset
REQ-024 SHALL, on rst high at a clock edge, enter IDLE, clear rsp_valid, rsp_atan, rsp_id, busy, internal x/y/z/i, and priority pointer to 0, from any state.
REQ-025 SHALL discard an in-flight job on reset mid-RUN or mid-DONE, producing no response for it.

Configuration
REQ-026 SHALL, with macro CORDIC_SCHED_RR_EN defined, arbitrate round-robin: after granting k, highest priority is (k+1) mod NREQ.
REQ-027 SHALL, without CORDIC_SCHED_RR_EN, arbitrate fixed priority, lowest index wins; priority pointer logic absent.

Structure
REQ-028 SHALL place the Q3.12 atan table constants, angle width (16), internal width (18), and the FSM state enum in shared package cordic_pkg.
REQ-029 SHALL split the iterative datapath (x/y/z registers, shift-add step, table lookup) into sub-module cordic_atan_iter, with cordic_atan_sched holding FSM, arbiter, and response registers.

Verification
REQ-030 SHALL check: req0 x=1000, y=0 -> rsp_valid 8 cycles after accept, rsp_id=0, |rsp_atan| <= 64.
REQ-031 SHALL check: req2 x=1000, y=1000 -> rsp_id=2, rsp_atan within 3217 +/- 64.
REQ-032 SHALL check: all four req_valid held high, RR build -> grant order 0,1,2,3,0; non-RR build -> 0,0,0.
REQ-033 SHALL check: rsp_ready low 5 cycles in DONE -> outputs stable, req_ready all-zero, busy high throughout.
REQ-034 SHALL check: rst pulsed on 3rd RUN cycle -> next cycle busy=0, rsp_valid=0, no response for that job, next grant to requester 0.
REQ-035 SHALL check: req_valid all-zero in IDLE -> req_ready all-zero, state stays IDLE, busy=0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared widths, FSM state type and the Q3.12 atan(2^-i) table for the
// iterative CORDIC arctangent scheduler.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int INT_W   = 18;
    localparam int OPER_W  = 16;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic signed [ANGLE_W-1:0] atan_tab(input logic [2:0] idx);
        logic signed [ANGLE_W-1:0] t;
        case (idx)
            3'd0:    t = 16'sd3217;
            3'd1:    t = 16'sd1899;
            3'd2:    t = 16'sd1003;
            3'd3:    t = 16'sd509;
            3'd4:    t = 16'sd256;
            3'd5:    t = 16'sd128;
            3'd6:    t = 16'sd64;
            default: t = 16'sd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cordic_atan_iter.sv
// Vectoring-mode CORDIC datapath: x/y/z registers, one shift-add rotation per
// step, angle table lookup. Drives y towards zero and accumulates the angle in z.
module cordic_atan_iter
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic signed [OPER_W-1:0]  x_in,
    input  logic signed [OPER_W-1:0]  y_in,
    output logic signed [ANGLE_W-1:0] z_next,
    output logic                      last
);

    logic signed [INT_W-1:0]   x, y, x_sh, y_sh, x_nxt, y_nxt;
    logic signed [ANGLE_W-1:0] z, t;
    logic [2:0]                i;
    logic                      y_pos;

    // Both updates use the pre-step x and y so the rotation is simultaneous.
    always_comb begin
        x_sh  = x >>> i;
        y_sh  = y >>> i;
        t     = atan_tab(i);
        y_pos = !y[INT_W-1] && (y != '0);
        if (y_pos) begin
            x_nxt  = x + y_sh;
            y_nxt  = y - x_sh;
            z_next = z + t;
        end else begin
            x_nxt  = x - y_sh;
            y_nxt  = y + x_sh;
            z_next = z - t;
        end
    end

    assign last = (i == 3'(ITERATIONS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            z <= '0;
            i <= '0;
        end else if (load) begin
            x <= {{(INT_W-OPER_W){x_in[OPER_W-1]}}, x_in};
            y <= {{(INT_W-OPER_W){y_in[OPER_W-1]}}, y_in};
            z <= '0;
            i <= '0;
        end else if (step) begin
            x <= x_nxt;
            y <= y_nxt;
            z <= z_next;
            i <= i + 3'd1;
        end
    end

endmodule

// File: rtl/cordic_atan_sched.sv
// Multi-requester arctangent engine: arbiter, IDLE/RUN/DONE control and response
// registers around cordic_atan_iter. Define CORDIC_SCHED_RR_EN for round-robin.
module cordic_atan_sched
    import cordic_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ITERATIONS = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OPER_W-1:0]    req_x,
    input  logic [NREQ*OPER_W-1:0]    req_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic signed [ANGLE_W-1:0] rsp_atan,
    output logic                      busy,
    output state_e                    dbg_state
);

    // Handshakes: a request transfers in a cycle where req_valid[k] and
    // req_ready[k] are both high; a response transfers when rsp_valid and
    // rsp_ready are both high. rsp_* hold steady while rsp_valid waits.

    state_e                    state, state_nxt;
    logic                      grant_any, load, step, last;
    logic [ID_W-1:0]           grant_idx, job_id;
    logic [NREQ-1:0]           sh;
    logic signed [OPER_W-1:0]  sel_x, sel_y;
    logic signed [ANGLE_W-1:0] z_next;

`ifdef CORDIC_SCHED_RR_EN
    logic [ID_W-1:0] ptr;
    int              k;

    // Scan from the pointer downwards in offset so the nearest request wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sh        = '0;
        k         = 0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            k = int'(ptr) + o;
            if (k >= NREQ) k = k - NREQ;
            sh = req_valid >> k;
            if (sh[0]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (load) ptr <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sh        = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            sh = req_valid >> j;
            if (sh[0]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end
`endif

    assign sel_x = req_x[int'(grant_idx)*OPER_W +: OPER_W];
    assign sel_y = req_y[int'(grant_idx)*OPER_W +: OPER_W];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: if (grant_any) begin
                load      = 1'b1;
                req_ready = NREQ'(1) << grant_idx;
                state_nxt = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_atan  <= '0;
            rsp_id    <= '0;
            job_id    <= '0;
        end else begin
            state <= state_nxt;
            if (load) job_id <= grant_idx;
            if (step && last) begin
                rsp_valid <= 1'b1;
                rsp_atan  <= z_next;
                rsp_id    <= job_id;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    cordic_atan_iter #(
        .ITERATIONS (ITERATIONS)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .x_in   (sel_x),
        .y_in   (sel_y),
        .z_next (z_next),
        .last   (last)
    );

endmodule

// File: tb/tb_cordic_atan_sched.sv
// Bench for cordic_atan_sched: directed jobs, arbitration order, DONE hold, mid-run
// reset. Define CORDIC_SCHED_RR_EN to expect round-robin grant order.
module tb_cordic_atan_sched;
    import cordic_pkg::*;

    localparam int NREQ       = 4;
    localparam int ITERATIONS = 7;
    localparam int W          = 19;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_x;
    logic [NREQ*16-1:0]   req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2:0]           rsp_id;
    logic [15:0]          rsp_atan;
    logic                 busy;
    state_e               dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cordic_atan_sched #(
        .NREQ       (NREQ),
        .ITERATIONS (ITERATIONS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_atan  (rsp_atan),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    int atan_t [0:6] = '{3217, 1899, 1003, 509, 256, 128, 64};

    function automatic int model_atan(input int x0, input int y0);
        int x, y, z, xn, yn;
        x = x0;
        y = y0;
        z = 0;
        for (int i = 0; i < ITERATIONS; i++) begin
            if (y > 0) begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + atan_t[i];
            end else begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - atan_t[i];
            end
            x = xn;
            y = yn;
        end
        return z;
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] s;
        for (int o = 0; o < NREQ; o++) begin
            s = v >> ((p + o) % NREQ);
            if (s[0]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] sx16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    bit           checking   = 1'b0;
    bit           model_idle = 1'b1;
    int           mptr       = 0;
    bit           prev_valid = 1'b0;
    bit           prev_ready = 1'b0;
    bit           prev_rst   = 1'b1;

    always @(negedge clk) begin
        int              g, ax, ay;
        logic [NREQ-1:0] exp_rr;
        logic [W-1:0]    e;
        if (checking) begin
            g      = model_idle ? model_grant(req_valid, mptr) : -1;
            exp_rr = (g >= 0) ? (NREQ'(1) << g) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_rr));
            check("busy", 32'(busy), 32'(!model_idle));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    check("rsp_id", 32'(rsp_id), 32'(e[18:16]));
                    check("rsp_atan", sx16(rsp_atan), sx16(e[15:0]));
                    if (!prev_valid) check("rsp_latency", 32'(cyc - acc_q[0]), 32'(ITERATIONS + 1));
                end
            end
            if (prev_valid && !prev_ready && !prev_rst) check("done_hold_valid", 32'(rsp_valid), 32'd1);

            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                model_idle = 1'b1;
                mptr       = 0;
            end else begin
                if (g >= 0) begin
                    ax = $signed(req_x[16*g +: 16]);
                    ay = $signed(req_y[16*g +: 16]);
                    exp_q.push_back({3'(g), 16'(model_atan(ax, ay))});
                    acc_q.push_back(cyc);
                    model_idle = 1'b0;
`ifdef CORDIC_SCHED_RR_EN
                    mptr = (g + 1) % NREQ;
`endif
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                    model_idle = 1'b1;
                end
            end
        end
        prev_valid = rsp_valid;
        prev_ready = rsp_ready;
        prev_rst   = rst;
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int k, input int x, input int y);
        req_x[16*k +: 16] = 16'(x);
        req_y[16*k +: 16] = 16'(y);
    endtask

    task automatic scramble();
        for (int k = 0; k < NREQ; k++) begin
            req_x[16*k +: 16] = 16'($urandom_range(0, 65535));
            req_y[16*k +: 16] = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic wait_grant(output int gid);
        bit got;
        got = 1'b0;
        gid = -1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1'b1;
                for (int k = 0; k < NREQ; k++)
                    if (((req_ready >> k) & NREQ'(1)) != '0) gid = k;
            end
        end
        if (!got) check("grant_timeout", 32'd0, 32'd1);
    endtask

    // Called right after a posedge; returns one cycle after the response handshake.
    task automatic run_job(input logic [NREQ-1:0] vmask, input logic [NREQ-1:0] during,
                           input int hold, input int hold_id, input int hold_atan, input bit keep,
                           output int gid, output int lat, output logic [2:0] id, output logic [15:0] atan);
        int acc;
        bit got;
        req_valid = vmask;
        wait_grant(gid);
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = during;
        scramble();
        got  = 1'b0;
        lat  = -1;
        id   = '0;
        atan = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        if (!got) begin
            check("rsp_timeout", 32'd0, 32'd1);
            req_valid = '0;
            return;
        end
        lat  = cyc - acc;
        id   = rsp_id;
        atan = rsp_atan;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_id", 32'(rsp_id), 32'(hold_id));
            check("hold_atan", sx16(rsp_atan), 32'(hold_atan));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = keep ? vmask : '0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    int          gid, lat, a;
    logic [2:0]  id;
    logic [15:0] atan;
    int          exp_order [0:4];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
`ifdef CORDIC_SCHED_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        checking = 1'b1;

        // Reset state and idle with no requests
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_atan", 32'(rsp_atan), 32'd0);
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_req_ready", 32'(req_ready), 32'd0);
            check("idle_state", 32'(dbg_state), 32'(IDLE));
        end

        // Hand-computed pins of the model
        check("model_1000_0", 32'(model_atan(1000, 0)), 32'd2);
        check("model_1000_1000", 32'(model_atan(1000, 1000)), 32'd3278);

        // atan(0) on requester 0
        @(posedge clk);
        #1;
        set_req(0, 1000, 0);
        run_job(4'b0001, '0, 0, 0, 0, 1'b0, gid, lat, id, atan);
        a = $signed(atan);
        check("t1_grant", 32'(gid), 32'd0);
        check("t1_latency", 32'(lat), 32'd8);
        check("t1_id", 32'(id), 32'd0);
        check("t1_abs_le_64", 32'(a <= 64 && a >= -64), 32'd1);
        check("t1_atan", sx16(atan), 32'd2);

        // atan(1) on requester 2
        set_req(2, 1000, 1000);
        run_job(4'b0100, '0, 0, 0, 0, 1'b0, gid, lat, id, atan);
        a = $signed(atan);
        check("t2_id", 32'(id), 32'd2);
        check("t2_range", 32'(a >= 3153 && a <= 3281), 32'd1);
        check("t2_atan", sx16(atan), 32'd3278);

        // Negative x: raw iteration result
        set_req(1, -500, 300);
        run_job(4'b0010, '0, 0, 0, 0, 1'b0, gid, lat, id, atan);
        check("t3_id", 32'(id), 32'd1);

        // Held response with other requesters waiting
        set_req(3, 300, -700);
        run_job(4'b1000, 4'b0011, 5, 3, model_atan(300, -700), 1'b0, gid, lat, id, atan);
        check("t4_id", 32'(id), 32'd3);

        // Arbitration order with all requesters asserted from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) set_req(k, 100 * (k + 1), 50 * k);
        for (int n = 0; n < 5; n++) begin
            run_job(4'b1111, 4'b1111, 0, 0, 0, (n < 4), gid, lat, id, atan);
            check("arb_grant", 32'(gid), 32'(exp_order[n]));
        end

        // Reset on the third RUN cycle discards the job and the priority pointer
        req_valid = 4'b0100;
        wait_grant(gid);
        check("rst_pre_grant", 32'(gid), 32'd2);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid_mid", 32'(rsp_valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;
        run_job(4'b1111, '0, 0, 0, 0, 1'b0, gid, lat, id, atan);
        check("post_rst_grant", 32'(gid), 32'd0);

        repeat (20) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
